mem_ctrl: RTL

- Memory-side responder for the instruction-fetch request interface, and the arbiter for data-stage loads/stores.
- Owns the single byte-wide unified RAM port (1-cycle read latency).
- Assembles 4 little-endian bytes into 32-bit instructions for fetch; serves byte/half/word data accesses.
- Reports the port's busy/conflict state back to fetch.

---
 rtl/mem_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: instruction-fetch responder and data load/store arbiter that owns the
// single byte-wide RAM port (1-cycle read latency). Fetches assemble four
// little-endian bytes; data accesses are byte/half/word.
// Optional: define ICACHE_EN to add a direct-mapped instruction cache.
module mem_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int ICACHE_ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_interception,
    output logic              addr_needed,
    output logic              inst_available,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] pc_back,
    output logic [1:0]        memcnf,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [1:0] {StIdle, StFetch, StDread, StDwrite} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, req_len;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q, asm_nxt;
    logic [31:0]       inst_q, rdata_q;
    logic [ADDR_W-1:0] pc_back_q;
    logic              inst_avail_q, done_q;
    logic              fetch_go, data_go, hit_go;
    logic              fetch_fin, read_fin, write_fin;
    logic              hit;
    logic [31:0]       hit_data;

    // Handshake qualifiers; data requests win over fetch in IDLE.
    always_comb begin
        addr_needed = !rst && (state_q == StIdle) && !mem_req && !branch_interception;
        fetch_go    = addr_needed;
        // The done cycle still sees the old request held high; ignore it.
        data_go     = (state_q == StIdle) && mem_req && !done_q;
        hit_go      = fetch_go && hit;
        case (mem_width)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [31:0]               c_data [ICACHE_ENTRIES];
    logic [TAG_W-1:0]          c_tag  [ICACHE_ENTRIES];
    logic [ICACHE_ENTRIES-1:0] c_valid;
    logic [IDX_W-1:0]          pc_idx, fill_idx, wr_idx;
    logic                      inval;

    // Cache lookup for the presented fetch address and invalidate on matching store.
    always_comb begin
        pc_idx   = pc_in[IDX_W+1:2];
        fill_idx = base_q[IDX_W+1:2];
        wr_idx   = mem_addr[IDX_W+1:2];
        hit      = c_valid[pc_idx] && (c_tag[pc_idx] == pc_in[ADDR_W-1:IDX_W+2]);
        hit_data = c_data[pc_idx];
        inval    = data_go && mem_we && c_valid[wr_idx] &&
                   (c_tag[wr_idx] == mem_addr[ADDR_W-1:IDX_W+2]);
    end

    // Line fill on completed (non-aborted) fetch; valid bits cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= '0;
        end else begin
            if (fetch_fin) begin
                c_valid[fill_idx] <= 1'b1;
                c_data[fill_idx]  <= asm_nxt;
                c_tag[fill_idx]   <= base_q[ADDR_W-1:IDX_W+2];
            end
            if (inval) begin
                c_valid[wr_idx] <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (ICACHE_ENTRIES > 0);
    assign hit        = 1'b0;
    assign hit_data   = '0;
`endif

    // Next-state logic; cnt counts cycles since acceptance minus one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 3'd1;
        fetch_fin = 1'b0;
        read_fin  = 1'b0;
        write_fin = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                if (data_go) begin
                    state_d = mem_we ? StDwrite : StDread;
                end else if (fetch_go && !hit) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (branch_interception) begin
                    state_d = StIdle;
                end else if (cnt_q == 3'd4) begin
                    state_d   = StIdle;
                    fetch_fin = 1'b1;
                end
            end
            StDread: begin
                if (cnt_q == len_q) begin
                    state_d  = StIdle;
                    read_fin = 1'b1;
                end
            end
            StDwrite: begin
                if (cnt_q == len_q - 3'd1) begin
                    state_d   = StIdle;
                    write_fin = 1'b1;
                end
            end
        endcase
    end

    // Byte assembly: the byte for address issued at cnt-1 arrives at cnt.
    always_comb begin
        asm_nxt = asm_q;
        if ((state_q == StFetch) || (state_q == StDread)) begin
            case (cnt_q)
                3'd1:    asm_nxt[7:0]   = ram_din;
                3'd2:    asm_nxt[15:8]  = ram_din;
                3'd3:    asm_nxt[23:16] = ram_din;
                3'd4:    asm_nxt[31:24] = ram_din;
                default: ;
            endcase
        end
    end

    // RAM port drive and conflict status.
    always_comb begin
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = 8'h00;
        memcnf   = 2'b00;
        case (state_q)
            StFetch: begin
                if (cnt_q < 3'd4) ram_a = base_q + ADDR_W'(cnt_q);
                if (mem_req) memcnf = 2'b10;
            end
            StDread: begin
                if (cnt_q < len_q) ram_a = base_q + ADDR_W'(cnt_q);
                memcnf = 2'b01;
            end
            StDwrite: begin
                ram_a    = base_q + ADDR_W'(cnt_q);
                ram_wr   = 1'b1;
                ram_dout = wdata_q[8*cnt_q[1:0] +: 8];
                memcnf   = 2'b01;
            end
            default: ;
        endcase
    end

    // State, request latches and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            len_q        <= 3'd0;
            base_q       <= '0;
            wdata_q      <= '0;
            asm_q        <= '0;
            inst_q       <= '0;
            rdata_q      <= '0;
            pc_back_q    <= '0;
            inst_avail_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inst_avail_q <= fetch_fin | hit_go;
            done_q       <= read_fin | write_fin;
            if (state_q == StIdle) begin
                asm_q <= '0;
                if (data_go) begin
                    base_q  <= mem_addr;
                    len_q   <= req_len;
                    wdata_q <= mem_wdata;
                end else if (fetch_go) begin
                    base_q <= pc_in;
                end
            end else begin
                asm_q <= asm_nxt;
            end
            if (fetch_fin) begin
                inst_q    <= asm_nxt;
                pc_back_q <= base_q;
            end else if (hit_go) begin
                inst_q    <= hit_data;
                pc_back_q <= pc_in;
            end
            if (read_fin) begin
                rdata_q <= asm_nxt;
            end
        end
    end

    assign inst_available = inst_avail_q;
    assign inst_out       = inst_q;
    assign pc_back        = pc_back_q;
    assign mem_done       = done_q;
    assign mem_rdata      = rdata_q;

endmodule
